// File: rtl/gomoku_pkg.sv
// Shared definitions for the board-level input blocks: key channel state
// encoding, board clock constant and a counter-width helper.
package gomoku_pkg;

  // Board system clock frequency in Hz.
  localparam int IN_FREQ_BOARD = 50000000;

  // Debounced key channel state.
  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2
  } key_state_e;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One debounced key: press/release debounce, long-press detection and
// auto-repeat, advancing only on sample ticks. Outputs are registered.
module key_channel
  import gomoku_pkg::*;
#(
  parameter int STABLE_SAMPLES = 20,
  parameter int LONG_SAMPLES   = 1000,
  parameter int REPEAT_SAMPLES = 200,
  parameter bit STICKY_EN      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic s,
  input  logic repeat_en,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat,
  output logic key_sticky
);

  localparam int SW = cnt_width(STABLE_SAMPLES - 1);
  localparam int HW = cnt_width(LONG_SAMPLES);
  localparam int RW = cnt_width(REPEAT_SAMPLES - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_SAMPLES);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_SAMPLES - 1);

  key_state_e    state_reg, state_next;
  logic [SW-1:0] stab_reg, stab_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [RW-1:0] rep_reg, rep_next;
  logic          level_reg, level_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;
  logic          long_reg, long_next;
  logic          repeat_reg, repeat_next;
  logic          sticky_reg, sticky_next;
  logic          release_done;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_UP;
      stab_reg    <= '0;
      hold_reg    <= '0;
      rep_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
      sticky_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      stab_reg    <= stab_next;
      hold_reg    <= hold_next;
      rep_reg     <= rep_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
      repeat_reg  <= repeat_next;
      sticky_reg  <= sticky_next;
    end
  end

  // Next-state logic; pulses default low so each lasts exactly one clk.
  always_comb begin
    state_next   = state_reg;
    stab_next    = stab_reg;
    hold_next    = hold_reg;
    rep_next     = rep_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    sticky_next  = sticky_reg;
    release_done = 1'b0;
    if (tick) begin
      case (state_reg)
        ST_UP: begin
          if (s) begin
            if (stab_reg == STAB_LAST) begin
              state_next = ST_DOWN;
              level_next = 1'b1;
              press_next = 1'b1;
              stab_next  = '0;
              hold_next  = '0;
              if (STICKY_EN) sticky_next = 1'b1;
            end else begin
              stab_next = stab_reg + 1'b1;
            end
          end else begin
            stab_next = '0;
          end
        end
        ST_DOWN, ST_LONG: begin
          // Release debounce runs in both held states and overrides long/repeat.
          if (!s) begin
            if (stab_reg == STAB_LAST) begin
              release_done = 1'b1;
              state_next   = ST_UP;
              level_next   = 1'b0;
              release_next = 1'b1;
              stab_next    = '0;
            end else begin
              stab_next = stab_reg + 1'b1;
            end
          end else begin
            stab_next = '0;
          end
          if (!release_done) begin
            if (state_reg == ST_DOWN) begin
              if (hold_reg != HOLD_MAX) hold_next = hold_reg + 1'b1;
              if (hold_reg == HOLD_LAST) begin
                long_next  = 1'b1;
                rep_next   = '0;
                state_next = ST_LONG;
              end
            end else begin
              if (rep_reg == REP_LAST) begin
                rep_next    = '0;
                repeat_next = repeat_en;
              end else begin
                rep_next = rep_reg + 1'b1;
              end
            end
          end
        end
        default: state_next = ST_UP;
      endcase
    end
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
  assign key_long    = long_reg;
  assign key_repeat  = repeat_reg;
  assign key_sticky  = sticky_reg;

endmodule

// File: rtl/key_input_bank.sv
// Bank of debounced key channels sharing one sample-tick prescaler.
// Raw pins are double-flopped, polarity-corrected, then fed to key_channel.
module key_input_bank
  import gomoku_pkg::*;
#(
  parameter int                 N_KEYS         = 4,
  parameter int                 IN_FREQ        = IN_FREQ_BOARD,
  parameter int                 SAMPLE_HZ      = 1000,
  parameter int                 STABLE_SAMPLES = 20,
  parameter int                 LONG_SAMPLES   = 1000,
  parameter int                 REPEAT_SAMPLES = 200,
  parameter bit                 ACTIVE_LOW     = 1'b0,
  parameter logic [N_KEYS-1:0]  STICKY_MASK    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_sticky,
  output logic              sample_tick
);

  localparam int DIV = IN_FREQ / SAMPLE_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [PW-1:0]     presc_reg;
  logic [N_KEYS-1:0] sync1_reg;
  logic [N_KEYS-1:0] sync2_reg;
  logic [N_KEYS-1:0] s;

  // Free-running prescaler 0..DIV-1; tick marks the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       presc_reg <= '0;
    else if (presc_reg == DIV_LAST) presc_reg <= '0;
    else                           presc_reg <= presc_reg + 1'b1;
  end

  assign sample_tick = (presc_reg == DIV_LAST);

  // Two-flop synchroniser, reset to the released pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= {N_KEYS{ACTIVE_LOW}};
      sync2_reg <= {N_KEYS{ACTIVE_LOW}};
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign s = ACTIVE_LOW ? ~sync2_reg : sync2_reg;

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
      key_channel #(
        .STABLE_SAMPLES(STABLE_SAMPLES),
        .LONG_SAMPLES  (LONG_SAMPLES),
        .REPEAT_SAMPLES(REPEAT_SAMPLES),
        .STICKY_EN     (STICKY_MASK[gi])
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .tick       (sample_tick),
        .s          (s[gi]),
        .repeat_en  (repeat_en[gi]),
        .key_level  (key_level[gi]),
        .key_press  (key_press[gi]),
        .key_release(key_release[gi]),
        .key_long   (key_long[gi]),
        .key_repeat (key_repeat[gi]),
        .key_sticky (key_sticky[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_input_bank.sv
// Testbench for key_input_bank: expected pulse events are queued with the
// sample-tick index at which they must appear and checked as the DUT emits them.
module tb_key_input_bank;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic [3:0] repeat_en;
  logic [3:0] key_level, key_press, key_release, key_long, key_repeat, key_sticky;
  logic       sample_tick;

  typedef struct {
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] rpt;
    int         tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_no = 0;
  logic tick_prev = 1'b0;

  key_input_bank #(
    .N_KEYS(4), .IN_FREQ(100), .SAMPLE_HZ(10),
    .STABLE_SAMPLES(3), .LONG_SAMPLES(8), .REPEAT_SAMPLES(4),
    .ACTIVE_LOW(1'b0), .STICKY_MASK(4'b0001)
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat), .key_sticky(key_sticky),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] t, input int tk);
    exp_t e;
    e.press = p; e.rel = r; e.lng = l; e.rpt = t; e.tick = tk;
    exp_q.push_back(e);
  endtask

  // One clock: sample after the edge, track ticks, score pulse outputs.
  task automatic step_clk();
    exp_t e;
    logic tick_inc;
    @(posedge clk);
    #1;
    tick_inc = tick_prev;
    if (tick_prev) tick_no++;
    tick_prev = sample_tick;
    if (|{key_press, key_release, key_long, key_repeat}) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse tick %0d got p=%b r=%b l=%b t=%b want none",
                 tick_no, key_press, key_release, key_long, key_repeat);
      end else begin
        e = exp_q.pop_front();
        if (!tick_inc || e.tick != tick_no || key_press !== e.press ||
            key_release !== e.rel || key_long !== e.lng || key_repeat !== e.rpt) begin
          errors++;
          $display("FAIL pulse tick %0d (edge=%0b) got p=%b r=%b l=%b t=%b want tick %0d p=%b r=%b l=%b t=%b",
                   tick_no, tick_inc, key_press, key_release, key_long, key_repeat,
                   e.tick, e.press, e.rel, e.lng, e.rpt);
        end else begin
          $display("tick %0d pulses p=%b r=%b l=%b t=%b ok",
                   tick_no, key_press, key_release, key_long, key_repeat);
        end
      end
    end else if (tick_inc && exp_q.size() > 0 && exp_q[0].tick <= tick_no) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL missed_pulse tick %0d got none want p=%b r=%b l=%b t=%b",
               tick_no, e.press, e.rel, e.lng, e.rpt);
    end
  endtask

  // Advance until the next tick edge has been processed (bounded).
  task automatic next_tick();
    int t0 = tick_no;
    int n = 0;
    while (tick_no == t0 && n < 4 * DIV) begin
      step_clk();
      n++;
    end
    if (tick_no == t0) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout got no tick in %0d clk want one every %0d", n, DIV);
    end
  endtask

  task automatic test_reset();
    int first = 0;
    rst = 1'b1; key_raw = '0; repeat_en = '0;
    repeat (3) step_clk();
    checks++;
    if ({key_level, key_press, key_release, key_long, key_repeat, key_sticky, sample_tick} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want all 0",
               {key_level, key_press, key_release, key_long, key_repeat, key_sticky, sample_tick});
    end
    rst = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      step_clk();
      if (first == 0 && tick_no == 1) first = c;
    end
    checks++;
    if (first != DIV) begin
      errors++;
      $display("FAIL first_tick got edge %0d want %0d", first, DIV);
    end
    checks++;
    if (tick_no != 200 / DIV) begin
      errors++;
      $display("FAIL tick_count got %0d want %0d", tick_no, 200 / DIV);
    end
    checks++;
    if (key_level !== 4'b0 || key_sticky !== 4'b0) begin
      errors++;
      $display("FAIL idle_levels got level=%b sticky=%b want 0000 0000", key_level, key_sticky);
    end
  endtask

  task automatic test_glitch();
    key_raw[0] = 1'b1;
    repeat (2) next_tick();
    key_raw[0] = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (key_level[0] !== 1'b0 || key_sticky[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level got level=%b sticky=%b want 0 0", key_level[0], key_sticky[0]);
    end
  endtask

  task automatic test_short_press();
    int t = tick_no;
    push(4'b0010, 4'b0, 4'b0, 4'b0, t + 3);
    push(4'b0, 4'b0010, 4'b0, 4'b0, t + 8);
    key_raw[1] = 1'b1;
    repeat (3) next_tick();
    checks++;
    if (key_level !== 4'b0010) begin
      errors++;
      $display("FAIL short_level_pressed got %b want 0010", key_level);
    end
    repeat (2) next_tick();
    key_raw[1] = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (key_level !== 4'b0000) begin
      errors++;
      $display("FAIL short_level_released got %b want 0000", key_level);
    end
  endtask

  task automatic test_long_repeat();
    int t = tick_no;
    push(4'b0100, 4'b0, 4'b0, 4'b0, t + 3);
    push(4'b0, 4'b0, 4'b0100, 4'b0, t + 11);
    push(4'b0, 4'b0, 4'b0, 4'b0100, t + 15);
    push(4'b0, 4'b0, 4'b0, 4'b0100, t + 19);
    push(4'b0, 4'b0100, 4'b0, 4'b0, t + 26);
    key_raw[2] = 1'b1;
    repeat_en[2] = 1'b1;
    repeat (19) next_tick();
    repeat_en[2] = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (key_level !== 4'b0100) begin
      errors++;
      $display("FAIL long_level_held got %b want 0100", key_level);
    end
    key_raw[2] = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (key_level !== 4'b0000) begin
      errors++;
      $display("FAIL long_level_released got %b want 0000", key_level);
    end
  endtask

  task automatic test_release_wins();
    int t = tick_no;
    push(4'b1000, 4'b0, 4'b0, 4'b0, t + 3);
    push(4'b0, 4'b1000, 4'b0, 4'b0, t + 11);
    key_raw[3] = 1'b1;
    repeat (8) next_tick();
    key_raw[3] = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (key_level !== 4'b0000) begin
      errors++;
      $display("FAIL race_level got %b want 0000", key_level);
    end
  endtask

  task automatic test_back_to_back();
    int t = tick_no;
    push(4'b1010, 4'b0, 4'b0, 4'b0, t + 3);
    push(4'b0, 4'b1010, 4'b0, 4'b0, t + 6);
    key_raw = 4'b1010;
    repeat (3) next_tick();
    checks++;
    if (key_level !== 4'b1010) begin
      errors++;
      $display("FAIL dual_level got %b want 1010", key_level);
    end
    key_raw = 4'b0000;
    repeat (4) next_tick();
  endtask

  task automatic test_sticky();
    int t = tick_no;
    checks++;
    if (key_sticky !== 4'b0000) begin
      errors++;
      $display("FAIL sticky_initial got %b want 0000", key_sticky);
    end
    push(4'b0001, 4'b0, 4'b0, 4'b0, t + 3);
    push(4'b0, 4'b0001, 4'b0, 4'b0, t + 6);
    key_raw[0] = 1'b1;
    repeat (3) next_tick();
    checks++;
    if (key_sticky !== 4'b0001) begin
      errors++;
      $display("FAIL sticky_first_press got %b want 0001", key_sticky);
    end
    key_raw[0] = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (key_sticky !== 4'b0001) begin
      errors++;
      $display("FAIL sticky_after_release got %b want 0001", key_sticky);
    end
    t = tick_no;
    push(4'b0001, 4'b0, 4'b0, 4'b0, t + 3);
    key_raw[0] = 1'b1;
    repeat (5) next_tick();
    checks++;
    if (key_sticky !== 4'b0001 || key_level !== 4'b0001) begin
      errors++;
      $display("FAIL sticky_second_hold got sticky=%b level=%b want 0001 0001", key_sticky, key_level);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (key_sticky !== 4'b0000 || key_level !== 4'b0000) begin
      errors++;
      $display("FAIL midhold_reset got sticky=%b level=%b want 0000 0000", key_sticky, key_level);
    end
    repeat (2) step_clk();
    rst = 1'b0;
    t = tick_no;
    push(4'b0001, 4'b0, 4'b0, 4'b0, t + 3);
    push(4'b0, 4'b0001, 4'b0, 4'b0, t + 6);
    repeat (3) next_tick();
    checks++;
    if (key_sticky !== 4'b0001 || key_level !== 4'b0001) begin
      errors++;
      $display("FAIL repress_after_reset got sticky=%b level=%b want 0001 0001", key_sticky, key_level);
    end
    key_raw[0] = 1'b0;
    repeat (4) next_tick();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_press();
    test_long_repeat();
    test_release_wins();
    test_back_to_back();
    test_sticky();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_input_bank.md
Name: key_input_bank

Overview:
- Parametrised successor to the single-key debouncer; replaces the per-key instances and the hand-written power latch in the board top.
- N_KEYS independent channels, each with:
  - 2-FF synchronisation and tick-sampled debounce
  - press/release pulses and a long-press pulse
  - auto-repeat, and an optional sticky (latch-once) output
- An internal prescaler generates the sample tick from the system clock, so no derived clock is needed.

Parameters:
- N_KEYS, 4, number of key channels.
- IN_FREQ, 50000000, system clock frequency in Hz.
- SAMPLE_HZ, 1000, debounce sample rate; DIV = IN_FREQ/SAMPLE_HZ, must be >= 2.
- STABLE_SAMPLES, 20, consecutive agreeing samples needed to accept a level change; must be >= 1.
- LONG_SAMPLES, 1000, held samples before key_long fires; must be > STABLE_SAMPLES.
- REPEAT_SAMPLES, 200, samples between auto-repeat pulses after long-press; must be >= 1.
- ACTIVE_LOW, 0, 1 = raw input is low when pressed (inverted after the synchroniser).
- STICKY_MASK, {N_KEYS{1'b0}}, bit i = 1 enables the sticky output on channel i.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_raw  in  N_KEYS  unsynchronised key pins.
- repeat_en  in  N_KEYS  per-channel auto-repeat enable, sampled on each tick.
- key_level  out  N_KEYS  debounced pressed level (1 = pressed).
- key_press  out  N_KEYS  one-clk pulse on accepted press.
- key_release  out  N_KEYS  one-clk pulse on accepted release.
- key_long  out  N_KEYS  one-clk pulse when the hold reaches LONG_SAMPLES.
- key_repeat  out  N_KEYS  one-clk auto-repeat pulses.
- key_sticky  out  N_KEYS  set on first accepted press; cleared only by rst; constant 0 where the STICKY_MASK bit is 0.
- sample_tick  out  1  one-clk prescaler tick, exported for reuse by other blocks.

Behaviour:
- Reset (async): all outputs 0, all counters 0, synchronisers 0 (after ACTIVE_LOW inversion, i.e. released), every channel in UP.
- Prescaler: counter 0..DIV-1 with width $clog2(DIV); sample_tick = 1 for the cycle where count == DIV-1, then the counter wraps to 0. The first tick occurs DIV cycles after reset release.
- Synchroniser: 2 flops per channel, then ACTIVE_LOW inversion, giving s[i]. Channel logic advances only on sample_tick cycles.
- Per-channel FSM:
  - UP: on a tick with s=1, stab_cnt++. On a tick with s=0, stab_cnt=0. When s=1 on the tick where stab_cnt == STABLE_SAMPLES-1, go to DOWN: key_level=1, key_press pulse, sticky set if masked, stab_cnt=0, hold_cnt=0.
  - DOWN: on each tick, hold_cnt++ (saturating at LONG_SAMPLES). When hold_cnt reaches LONG_SAMPLES, key_long pulses once, rep_cnt=0, go to LONG. Release debouncing runs in parallel using the mirror rule (s=0 counts, s=1 clears); on acceptance go to UP with key_level=0 and a key_release pulse.
  - LONG: on each tick, rep_cnt++. When rep_cnt == REPEAT_SAMPLES-1, rep_cnt=0 and key_repeat pulses if repeat_en[i]; if repeat_en is low, rep_cnt still wraps but no pulse is issued. Release debouncing runs as in DOWN.
- All outputs are registered and update on the clock edge of the deciding tick; a pulse lasts exactly one clk.
- Press latency from a raw edge: 2 clk synchroniser plus STABLE_SAMPLES ticks.
- Boundary cases:
  - A glitch shorter than STABLE_SAMPLES ticks resets stab_cnt and produces no output.
  - If release is accepted on the same tick that long or repeat would fire, the release wins; no long/repeat pulse is issued.
  - Channels are fully independent; simultaneous presses give simultaneous pulses.
  - rst asserted mid-hold clears everything immediately, including sticky. After reset, a still-held key is debounced as a new press.
  - Counter widths: $clog2(max+1), with no overflow.

Decomposition:
- Shared package (gomoku_pkg):
  - channel state encoding: UP, DOWN, LONG (2 bits)
  - common frequency constants (IN_FREQ_BOARD = 50000000)
- Sub-module key_channel: one FSM plus counters per channel, instantiated N_KEYS times in a generate loop.
- The prescaler and synchronisers stay in key_input_bank.

Test Plan (sim params: IN_FREQ=100, SAMPLE_HZ=10 so DIV=10; STABLE=3, LONG=8, REPEAT=4; N_KEYS=4; ACTIVE_LOW=0; STICKY_MASK=4'b0001):
- Hold rst, release it, leave keys idle for 200 clk -> all outputs 0; sample_tick every 10 clk, first at clk 10.
- Key0 high for 2 ticks then low (glitch) -> no key_press; key_level[0] stays 0.
- Key1 pressed and held 5 ticks, then released -> one key_press at the 3rd high tick; key_release at the 3rd low tick; no key_long.
- Key2 held 20 ticks with repeat_en[2]=1, then repeat_en[2]=0 at tick 16 -> key_long at hold tick 8; key_repeat at ticks 12 and 16 only.
- Key0 pressed and released twice -> key_sticky[0]=1 after the first press and stays 1; key_sticky[3:1]=0; rst mid-hold clears sticky and key_level in the same cycle.
- Keys 1 and 3 pressed on the same clk -> key_press[1] and key_press[3] asserted in the same cycle.
